// File: rtl/warmboot_pkg.sv
// warmboot_pkg: shared types and constants for the iCE40 warm-boot controller.
package warmboot_pkg;
   localparam int IMG_W = 2;
   localparam int KEY_W = 8;
   localparam logic [IMG_W-1:0] GOLDEN_IMAGE = 2'd0;
   typedef enum logic [1:0] {IDLE, DRAIN, BOOT} state_t;
endpackage

// File: rtl/warmboot_prim.sv
// warmboot_prim: pin-level hookup of the SB_WARMBOOT BOOT, S1 and S0 inputs.
import warmboot_pkg::*;
module warmboot_prim (
   input  logic             boot,
   input  logic [IMG_W-1:0] sel,
   output logic             pin_boot,
   output logic             pin_s1,
   output logic             pin_s0
);
   assign pin_boot = boot;
   assign pin_s1   = sel[1];
   assign pin_s0   = sel[0];
endmodule

// File: rtl/warmboot_ctrl.sv
// warmboot_ctrl: validates keyed image requests, waits for a continuous UART/SPI
// quiet period, then asserts warm boot; an optional watchdog falls back to the golden image.
import warmboot_pkg::*;
module warmboot_ctrl #(
   parameter int              NUM_IMAGES   = 4,
   parameter int              DRAIN_CYCLES = 1024,
   parameter int              WDT_CYCLES   = 0,
   parameter logic [KEY_W-1:0] BOOT_KEY    = 8'hB0,
   parameter bit              USE_PRIM     = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [IMG_W-1:0] req_image,
   input  logic [KEY_W-1:0] req_key,
   input  logic             uart_tx_idle,
   input  logic             spi_idle,
   input  logic             wdt_kick,
   output logic             boot,
   output logic [IMG_W-1:0] sel,
   output logic             busy,
   output logic             err,
   output logic             wdt_fired
);
   localparam int DW = $clog2(DRAIN_CYCLES + 1);
   localparam int WW = WDT_CYCLES > 1 ? $clog2(WDT_CYCLES) : 1;
   localparam logic [DW-1:0] D_LAST = DW'(DRAIN_CYCLES);
   localparam logic [WW-1:0] W_LAST = WW'(WDT_CYCLES > 0 ? WDT_CYCLES - 1 : 0);

   state_t           state;
   logic [DW-1:0]    idle_cnt;
   logic [WW-1:0]    wdt_cnt;
   logic             boot_q;
   logic [IMG_W-1:0] sel_q;
   logic             quiet;
   logic             wdt_expire;
   logic             req_ok;

   assign quiet      = uart_tx_idle && spi_idle;
   assign wdt_expire = (WDT_CYCLES > 0) && (state == IDLE) && (wdt_cnt == W_LAST) && !wdt_kick;
   assign req_ready  = (state == IDLE) && !wdt_expire;
   assign req_ok     = (req_key == BOOT_KEY) && (int'(req_image) < NUM_IMAGES);

   // The idle counter reaches DRAIN_CYCLES only after that many unbroken quiet
   // cycles in DRAIN, so sel is settled well before boot rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         boot_q    <= 1'b0;
         sel_q     <= GOLDEN_IMAGE;
         busy      <= 1'b0;
         err       <= 1'b0;
         wdt_fired <= 1'b0;
         idle_cnt  <= '0;
         wdt_cnt   <= '0;
      end else begin
         err     <= 1'b0;
         wdt_cnt <= (state != IDLE || wdt_kick || wdt_expire) ? '0 : wdt_cnt + 1'b1;
         case (state)
            IDLE: begin
               if (wdt_expire) begin
                  sel_q     <= GOLDEN_IMAGE;
                  wdt_fired <= 1'b1;
                  busy      <= 1'b1;
                  idle_cnt  <= '0;
                  state     <= DRAIN;
               end else if (req_valid && req_ok) begin
                  sel_q    <= req_image;
                  busy     <= 1'b1;
                  idle_cnt <= '0;
                  state    <= DRAIN;
               end else if (req_valid) begin
                  err <= 1'b1;
               end
            end
            DRAIN: begin
               if (quiet && idle_cnt == D_LAST) begin
                  boot_q <= 1'b1;
                  state  <= BOOT;
               end else begin
                  idle_cnt <= quiet ? idle_cnt + 1'b1 : '0;
               end
            end
            default: ;
         endcase
      end
   end

   generate
      if (USE_PRIM) begin : g_prim
         warmboot_prim u_prim (
            .boot    (boot_q),
            .sel     (sel_q),
            .pin_boot(boot),
            .pin_s1  (sel[1]),
            .pin_s0  (sel[0])
         );
      end else begin : g_pins
         assign boot = boot_q;
         assign sel  = sel_q;
      end
   endgenerate
endmodule

// File: tb/tb_warmboot_ctrl.sv
// tb_warmboot_ctrl: directed checks of request validation, drain timing,
// watchdog fallback and asynchronous reset on two parameterisations.
module tb_warmboot_ctrl;
   logic       clk = 0;
   logic       rst_n = 1;
   logic       valid_a = 0, valid_w = 0, kick_a = 0, kick_w = 1;
   logic [1:0] img = 0;
   logic [7:0] key = 0;
   logic       uart = 1, spi = 1;
   logic       ready_a, boot_a, busy_a, err_a, fired_a;
   logic       ready_w, boot_w, busy_w, err_w, fired_w;
   logic [1:0] sel_a, sel_w;
   int         n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   warmboot_ctrl #(.NUM_IMAGES(4), .DRAIN_CYCLES(16), .WDT_CYCLES(0), .BOOT_KEY(8'hB0), .USE_PRIM(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .req_valid(valid_a), .req_ready(ready_a), .req_image(img),
      .req_key(key), .uart_tx_idle(uart), .spi_idle(spi), .wdt_kick(kick_a), .boot(boot_a),
      .sel(sel_a), .busy(busy_a), .err(err_a), .wdt_fired(fired_a));

   warmboot_ctrl #(.NUM_IMAGES(2), .DRAIN_CYCLES(16), .WDT_CYCLES(100), .BOOT_KEY(8'hB0), .USE_PRIM(0)) dut_w (
      .clk(clk), .rst_n(rst_n), .req_valid(valid_w), .req_ready(ready_w), .req_image(img),
      .req_key(key), .uart_tx_idle(uart), .spi_idle(spi), .wdt_kick(kick_w), .boot(boot_w),
      .sel(sel_w), .busy(busy_w), .err(err_w), .wdt_fired(fired_w));

   // Stand-in for the primitive: report the image chosen at the BOOT rise.
   always @(posedge boot_a) $display("dut_a warm boot to image %0d", sel_a);

   typedef struct {
      logic [7:0] key;
      logic [1:0] img;
      logic       exp_err;
      logic       exp_busy;
      logic [1:0] exp_sel;
   } vec_t;
   vec_t vecs[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic wait_boot_a(output int k);
      k = 0;
      while (!boot_a && k < 60) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic accept_a(input logic [1:0] i);
      img = i;
      key = 8'hB0;
      valid_a = 1;
      chk("ready_a_idle", ready_a, 1);
      step(1);
      valid_a = 0;
   endtask

   initial begin
      int k;
      logic seen;
      vecs[0] = '{8'hAA, 2'd1, 1'b1, 1'b0, 2'd0};
      vecs[1] = '{8'hB0, 2'd3, 1'b1, 1'b0, 2'd0};
      vecs[2] = '{8'hB0, 2'd2, 1'b1, 1'b0, 2'd0};
      vecs[3] = '{8'h5A, 2'd0, 1'b1, 1'b0, 2'd0};
      vecs[4] = '{8'hB0, 2'd1, 1'b0, 1'b1, 2'd1};
      vecs[5] = '{8'hB0, 2'd0, 1'b0, 1'b1, 2'd0};

      #1 rst_n = 0;
      #1;
      chk("rst_boot", boot_a, 0);
      chk("rst_sel", sel_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_err", err_a, 0);
      chk("rst_fired", fired_w, 0);
      @(negedge clk);
      rst_n = 1;
      chk("rst_ready", ready_a, 1);

      // Request validation on the two-image instance; kick_w holds the watchdog off.
      for (int i = 0; i < 6; i++) begin
         do_reset();
         img = vecs[i].img;
         key = vecs[i].key;
         valid_w = 1;
         chk($sformatf("v%0d_ready", i), ready_w, 1);
         step(1);
         valid_w = 0;
         chk($sformatf("v%0d_err", i), err_w, vecs[i].exp_err);
         chk($sformatf("v%0d_busy", i), busy_w, vecs[i].exp_busy);
         chk($sformatf("v%0d_sel", i), sel_w, vecs[i].exp_sel);
         step(1);
         chk($sformatf("v%0d_err_clr", i), err_w, 0);
         chk($sformatf("v%0d_noboot", i), boot_w, 0);
      end

      // Valid request: boot rises 17 edges after the accepting edge.
      do_reset();
      accept_a(2'd2);
      chk("acc_sel", sel_a, 2);
      chk("acc_busy", busy_a, 1);
      chk("acc_ready", ready_a, 0);
      chk("acc_boot_early", boot_a, 0);
      wait_boot_a(k);
      chk("acc_boot_latency", k, 17);
      chk("boot_sel_hold", sel_a, 2);
      chk("boot_ready", ready_a, 0);
      chk("boot_busy", busy_a, 1);

      // Drain interrupted at idle_cnt=10 for three cycles restarts the count.
      do_reset();
      accept_a(2'd3);
      step(10);
      uart = 0;
      step(3);
      chk("intr_no_boot", boot_a, 0);
      uart = 1;
      wait_boot_a(k);
      chk("intr_boot_latency", k, 17);
      chk("intr_sel", sel_a, 3);

      // Asynchronous reset mid-DRAIN, fresh request, then reset in BOOT.
      do_reset();
      accept_a(2'd2);
      step(5);
      #2 rst_n = 0;
      #1;
      chk("drain_rst_busy", busy_a, 0);
      chk("drain_rst_sel", sel_a, 0);
      chk("drain_rst_boot", boot_a, 0);
      @(negedge clk);
      rst_n = 1;
      accept_a(2'd1);
      wait_boot_a(k);
      chk("fresh_boot_latency", k, 17);
      chk("fresh_sel", sel_a, 1);
      #2 rst_n = 0;
      #1;
      chk("boot_rst_boot", boot_a, 0);
      chk("boot_rst_sel", sel_a, 0);
      chk("boot_rst_busy", busy_a, 0);
      @(negedge clk);
      rst_n = 1;

      // Watchdog expiry with no kick: DRAIN on the 100th edge, golden image.
      kick_w = 0;
      do_reset();
      k = 0;
      while (!busy_w && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("wdt_drain_edge", k, 100);
      chk("wdt_sel", sel_w, 0);
      chk("wdt_fired", fired_w, 1);
      chk("wdt_err", err_w, 0);
      k = 0;
      while (!boot_w && k < 60) begin
         @(negedge clk);
         k++;
      end
      chk("wdt_boot_latency", k, 17);
      #2 rst_n = 0;
      #1;
      chk("wdt_rst_boot", boot_w, 0);
      chk("wdt_rst_fired", fired_w, 0);
      chk("wdt_rst_busy", busy_w, 0);
      @(negedge clk);
      rst_n = 1;

      // Kicks every 50 cycles keep the controller idle.
      do_reset();
      seen = 0;
      for (int i = 0; i < 1000; i++) begin
         kick_w = (i % 50 == 0);
         @(negedge clk);
         if (busy_w || boot_w) seen = 1;
      end
      kick_w = 0;
      chk("kick_no_boot", seen, 0);

      // Request on the expiry cycle loses to the watchdog.
      do_reset();
      step(99);
      chk("coll_ready", ready_w, 0);
      img = 2'd3;
      key = 8'hB0;
      valid_w = 1;
      step(1);
      valid_w = 0;
      chk("coll_busy", busy_w, 1);
      chk("coll_sel", sel_w, 0);
      chk("coll_fired", fired_w, 1);
      chk("coll_err", err_w, 0);

      // Kick on the expiry cycle clears the counter and restarts the timeout.
      do_reset();
      step(99);
      kick_w = 1;
      step(1);
      kick_w = 0;
      chk("kick_exp_idle", busy_w, 0);
      step(99);
      chk("kick_exp_still_idle", busy_w, 0);
      step(1);
      chk("kick_exp_refire", busy_w, 1);
      kick_w = 1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
